// File: rtl/fp_8_8_pkg.sv
// Shared definitions for the 8-bit-exponent / 8-bit-fraction float format
// used by fdiv_iter and fmul.
// Word layout: [18:17] exc, [16] sign, [15:8] biased exponent, [7:0] fraction
// (implicit leading 1 for normals).
package fp_8_8_pkg;

    localparam int WE   = 8;
    localparam int WF   = 8;
    localparam int BIAS = 127;

    typedef enum logic [1:0] {
        EXC_ZERO = 2'b00,
        EXC_NORM = 2'b01,
        EXC_INF  = 2'b10,
        EXC_NAN  = 2'b11
    } exc_t;

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        ROUND,
        DONE
    } state_t;

endpackage

// File: rtl/fdiv_round_pack.sv
// Normalise, round-to-nearest-even and exception-pack the raw divider result.
// Ports:
//   q    - 11-bit quotient floor(sigX*2^10/sigY)
//   rem  - final remainder of the division
//   e    - 10-bit two's-complement biased exponent (already adjusted by q[10])
//   sign - result sign
//   r    - packed result word
module fdiv_round_pack
    import fp_8_8_pkg::*;
(
    input  logic [10:0]          q,
    input  logic [9:0]           rem,
    input  logic [9:0]           e,
    input  logic                 sign,
    output logic [WE+WF+2:0]     r
);

    logic [WF-1:0] frac;
    logic          guard;
    logic          sticky;
    logic          rnd;
    logic [17:0]   sum;

    always_comb begin
        if (q[10]) begin
            frac   = q[9:2];
            guard  = q[1];
            sticky = q[0] | (rem != '0);
        end else begin
            frac   = q[8:1];
            guard  = q[0];
            sticky = (rem != '0);
        end
        rnd = guard & (sticky | frac[0]);
        // Carry out of the fraction rolls into the exponent field.
        sum = {e, frac} + {17'd0, rnd};

        r = '0;
        r[16] = sign;
        // sum[17] set means a negative exponent (underflow); [16] alone is overflow.
        if (sum[17]) begin
            r[18:17] = EXC_ZERO;
        end else if (sum[16]) begin
            r[18:17] = EXC_INF;
        end else begin
            r[18:17] = EXC_NORM;
            r[15:0]  = sum[15:0];
        end
    end

endmodule

// File: rtl/fdiv_iter.sv
// Iterative floating-point divider R = X / Y (restoring division, one
// quotient bit per cycle) with valid/ready handshakes on both sides.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   in_valid / in_ready - operand handshake (in_ready high only in IDLE)
//   X, Y                - dividend, divisor
//   R                   - quotient, held stable while out_valid is high
//   out_valid/out_ready - result handshake
module fdiv_iter
    import fp_8_8_pkg::*;
#(
    parameter int ID = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [18:0] X,
    input  logic [18:0] Y,
    output logic [18:0] R,
    output logic        out_valid,
    input  logic        out_ready
);

    state_t      state;
    logic [3:0]  cnt;
    logic [10:0] q;
    logic [9:0]  rem;
    logic [WF:0] sig_y;
    logic [9:0]  ediff;
    logic        sign;

    exc_t        exc_x;
    exc_t        exc_y;
    logic        res_sign;
    logic [18:0] special_r;
    logic        ge;
    logic [9:0]  rdiff;
    logic [9:0]  e_adj;
    logic [18:0] packed_r;

    assign in_ready = (state == IDLE);
    assign exc_x    = exc_t'(X[18:17]);
    assign exc_y    = exc_t'(Y[18:17]);
    assign res_sign = X[16] ^ Y[16];

    always_comb begin
        special_r     = '0;
        special_r[16] = res_sign;
        if (exc_x == EXC_NAN || exc_y == EXC_NAN ||
            (exc_x == EXC_ZERO && exc_y == EXC_ZERO) ||
            (exc_x == EXC_INF  && exc_y == EXC_INF)) begin
            special_r[18:17] = EXC_NAN;
        end else if (exc_x == EXC_ZERO || exc_y == EXC_INF) begin
            special_r[18:17] = EXC_ZERO;
        end else begin
            special_r[18:17] = EXC_INF;
        end
    end

    // Partial remainder stays below 2*sigY, so 10 bits never overflow.
    assign ge    = (rem >= {1'b0, sig_y});
    assign rdiff = ge ? (rem - {1'b0, sig_y}) : rem;
    assign e_adj = ediff - {9'd0, ~q[10]};

    fdiv_round_pack u_round_pack (
        .q    (q),
        .rem  (rem),
        .e    (e_adj),
        .sign (sign),
        .r    (packed_r)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            q         <= '0;
            rem       <= '0;
            sig_y     <= '0;
            ediff     <= '0;
            sign      <= 1'b0;
            R         <= '0;
            out_valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (exc_x == EXC_NORM && exc_y == EXC_NORM) begin
                            state <= DIV;
                            cnt   <= '0;
                            q     <= '0;
                            rem   <= {2'b01, X[WF-1:0]};
                            sig_y <= {1'b1, Y[WF-1:0]};
                            ediff <= {2'b00, X[15:8]} - {2'b00, Y[15:8]} + 10'(BIAS);
                            sign  <= res_sign;
                        end else begin
                            state     <= DONE;
                            R         <= special_r;
                            out_valid <= 1'b1;
                        end
                    end
                end
                DIV: begin
                    q   <= {q[9:0], ge};
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd10) begin
                        rem   <= rdiff;
                        state <= ROUND;
                    end else begin
                        rem <= {rdiff[8:0], 1'b0};
                    end
                end
                ROUND: begin
                    R         <= packed_r;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fdiv_iter.sv
// Self-checking bench for fdiv_iter: directed cases, randomized normal and
// special operands against an arithmetic reference model, backpressure,
// back-to-back issue and reset abort.
module tb_fdiv_iter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [18:0] X;
    logic [18:0] Y;
    logic [18:0] R;
    logic        out_valid;
    logic        out_ready;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fdiv_iter #(.ID(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .X         (X),
        .Y         (Y),
        .R         (R),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    // Reference: quotient from integer division of the significands.
    function automatic logic [18:0] model_div(input logic [18:0] x, input logic [18:0] y);
        int ex, ey, sx, sy, num, qq, rm, e, fr, g, st, rnd, sum;
        logic s;
        logic [18:0] res;
        s  = x[16] ^ y[16];
        ex = int'(x[18:17]);
        ey = int'(y[18:17]);
        res = '0;
        res[16] = s;
        if (ex == 3 || ey == 3 || (ex == 0 && ey == 0) || (ex == 2 && ey == 2)) begin
            res[18:17] = 2'b11;
            return res;
        end
        if (ex == 0 || ey == 2) begin
            res[18:17] = 2'b00;
            return res;
        end
        if (ex != 1 || ey != 1) begin
            res[18:17] = 2'b10;
            return res;
        end
        sx  = 256 + int'(x[7:0]);
        sy  = 256 + int'(y[7:0]);
        num = sx * 1024;
        qq  = num / sy;
        rm  = num % sy;
        e   = int'(x[15:8]) - int'(y[15:8]) + 127 - ((qq >= 1024) ? 0 : 1);
        if (qq >= 1024) begin
            fr = (qq / 4) % 256;
            g  = (qq / 2) % 2;
            st = ((qq % 2) != 0 || rm != 0) ? 1 : 0;
        end else begin
            fr = (qq / 2) % 256;
            g  = qq % 2;
            st = (rm != 0) ? 1 : 0;
        end
        rnd = (g == 1 && (st == 1 || (fr % 2) == 1)) ? 1 : 0;
        sum = e * 256 + fr + rnd;
        if (sum < 0) begin
            res[18:17] = 2'b00;
        end else if (sum > 65535) begin
            res[18:17] = 2'b10;
        end else begin
            res[18:17] = 2'b01;
            res[15:0]  = sum[15:0];
        end
        return res;
    endfunction

    // Issue one operation; returns R and the number of edges from acceptance
    // (acceptance edge = 1) until out_valid is seen, or -1 on timeout.
    task automatic run_op(input logic [18:0] x, input logic [18:0] y,
                          output logic [18:0] r, output int lat);
        int wait_cnt;
        wait_cnt = 0;
        @(negedge clk);
        while (!in_ready && wait_cnt < 50) begin
            @(negedge clk);
            wait_cnt++;
        end
        X = x;
        Y = y;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        X = 19'($urandom);
        Y = 19'($urandom);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!out_valid) lat = -1;
        r = R;
        if (out_ready) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || R !== 19'h0) begin
            errors++;
            $display("FAIL reset: in_ready=%b out_valid=%b R=%h, want 1 0 00000", in_ready, out_valid, R);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [18:0] r;
        int lat;
        run_op(19'h28080, 19'h28000, r, lat);
        checks++;
        if (r !== 19'h27F80) begin
            errors++;
            $display("FAIL div_3_2: R=%h want 27f80", r);
        end
        checks++;
        if (lat !== 13) begin
            errors++;
            $display("FAIL lat_3_2: latency=%0d want 13", lat);
        end
        run_op(19'h27F00, 19'h28080, r, lat);
        checks++;
        if (r !== 19'h27D55) begin
            errors++;
            $display("FAIL div_1_3: R=%h want 27d55", r);
        end
    endtask

    task automatic test_special();
        logic [18:0] r;
        int lat;
        run_op(19'h27F00, 19'h00000, r, lat);
        checks++;
        if (r !== 19'h40000 || lat !== 1) begin
            errors++;
            $display("FAIL div_by_zero: R=%h lat=%0d want 40000 lat 1", r, lat);
        end
        run_op(19'h00000, 19'h00000, r, lat);
        checks++;
        if (r !== 19'h60000) begin
            errors++;
            $display("FAIL zero_zero: R=%h want 60000", r);
        end
        run_op(19'h60000, 19'h27F00, r, lat);
        checks++;
        if (r[18:17] !== 2'b11) begin
            errors++;
            $display("FAIL nan_in: R=%h want exc 11", r);
        end
    endtask

    task automatic test_range();
        logic [18:0] r;
        int lat;
        run_op(19'h2FE00, 19'h20100, r, lat);
        checks++;
        if (r !== 19'h40000) begin
            errors++;
            $display("FAIL overflow: R=%h want 40000", r);
        end
        run_op(19'h20100, 19'h2FE00, r, lat);
        checks++;
        if (r !== 19'h00000) begin
            errors++;
            $display("FAIL underflow: R=%h want 00000", r);
        end
    endtask

    task automatic test_random();
        logic [18:0] x, y, r, exp_r;
        int lat, exp_lat;
        for (int i = 0; i < 60; i++) begin
            x = 19'($urandom);
            y = 19'($urandom);
            if (i < 40) begin
                x[18:17] = 2'b01;
                y[18:17] = 2'b01;
            end else if (x[18:17] == 2'b01 && y[18:17] == 2'b01) begin
                y[18:17] = 2'(i % 4 == 1 ? 0 : i % 4);
            end
            exp_r   = model_div(x, y);
            exp_lat = (x[18:17] == 2'b01 && y[18:17] == 2'b01) ? 13 : 1;
            run_op(x, y, r, lat);
            checks++;
            if (r !== exp_r || lat !== exp_lat) begin
                errors++;
                $display("FAIL random[%0d]: X=%h Y=%h R=%h lat=%0d want %h lat %0d",
                         i, x, y, r, lat, exp_r, exp_lat);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [18:0] r;
        int lat;
        logic bad;
        out_ready = 1'b0;
        run_op(19'h28080, 19'h28000, r, lat);
        checks++;
        if (r !== 19'h27F80 || lat !== 13) begin
            errors++;
            $display("FAIL bp_result: R=%h lat=%0d want 27f80 lat 13", r, lat);
        end
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            X = 19'h27F00;
            Y = 19'h27F00;
            @(posedge clk);
            #1;
            if (out_valid !== 1'b1 || R !== 19'h27F80 || in_ready !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL bp_hold: out_valid=%b R=%h in_ready=%b want 1 27f80 0", out_valid, R, in_ready);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
        end
        run_op(19'h27F00, 19'h28080, r, lat);
        checks++;
        if (r !== 19'h27D55) begin
            errors++;
            $display("FAIL bp_ignored: R=%h want 27d55", r);
        end
    endtask

    task automatic test_back_to_back();
        logic [18:0] r;
        int lat;
        run_op(19'h28080, 19'h28000, r, lat);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready: in_ready=%b want 1 right after handshake", in_ready);
        end
        run_op(19'h27F00, 19'h28080, r, lat);
        checks++;
        if (r !== 19'h27D55 || lat !== 13) begin
            errors++;
            $display("FAIL b2b_second: R=%h lat=%0d want 27d55 lat 13", r, lat);
        end
    endtask

    task automatic test_reset_mid_div();
        logic seen;
        int lat;
        @(negedge clk);
        X = 19'h28080;
        Y = 19'h28000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || R !== 19'h0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid: out_valid=%b R=%h in_ready=%b want 0 00000 1", out_valid, R, in_ready);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL rst_abort: out_valid=1 after reset, want 0");
        end
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        X = 19'h27F00;
        Y = 19'h27F00;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_first_accept: in_ready=%b want 0 after first edge", in_ready);
        end
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checks++;
        if (out_valid !== 1'b1 || R !== 19'h27F00 || lat !== 13) begin
            errors++;
            $display("FAIL rst_then_1_1: out_valid=%b R=%h lat=%0d want 1 27f00 lat 13", out_valid, R, lat);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        X         = '0;
        Y         = '0;
        test_reset();
        test_directed();
        test_special();
        test_range();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_div();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fdiv_iter.md
FDIV_ITER -- requirements
Module: fdiv_iter

Interface
REQ-001 The module SHALL have parameter ID, default 1, meaning instance tag with no functional effect.
REQ-002 The clock port SHALL be clk  input  1  the only clock; all state updates on its rising edge.
REQ-003 The reset port SHALL be rst_n  input  1  asynchronous, active-low reset.
REQ-004 The port in_valid  input  1  SHALL flag that X and Y carry an operand pair.
REQ-005 The port in_ready  output  1  SHALL equal (state==IDLE), combinationally.
REQ-006 The ports X, Y  input  19 each  SHALL be dividend and divisor: [18:17] exc (00 zero, 01 normal, 10 inf, 11 NaN), [16] sign, [15:8] exponent (bias 127), [7:0] fraction with implicit leading 1.
REQ-007 The port R  output  19  SHALL be the quotient X/Y in the same format.
REQ-008 The port out_valid  output  1  SHALL flag that R holds a result.
REQ-009 The port out_ready  input  1  SHALL flag that the consumer accepts R.

Function
REQ-010 The FSM SHALL have states IDLE, DIV, ROUND and DONE.
REQ-011 An operand pair SHALL be accepted on the edge where in_valid&in_ready is high, and X/Y SHALL be ignored at all other times.
REQ-012 On acceptance, if both operands have exc 01 the FSM SHALL go to DIV; otherwise it SHALL go to DONE with the special result.
REQ-013 Special results SHALL follow this table; the sign SHALL always be X[16]^Y[16] (sign bit also set on NaN/zero/inf):
      - any NaN, 0/0 or inf/inf -> 11;
      - 0/normal, 0/inf or normal/inf -> 00;
      - normal/0, inf/0 or inf/normal -> 10;
      - exp/frac -> 0.
REQ-014 DIV SHALL run restoring division for exactly 11 cycles, one quotient bit per cycle, MSB first, producing q = floor(sigX*2^10/sigY) (11 bits) and a 10-bit remainder, where sig = {1,frac}.
REQ-015 The biased exponent SHALL be computed as a 10-bit two's-complement value: e = expX - expY + 127 - (q[10] ? 0 : 1).
REQ-016 Normalisation SHALL be:
      - if q[10]: frac = q[9:2], guard = q[1], sticky = q[0] | (rem!=0);
      - else: frac = q[8:1], guard = q[0], sticky = (rem!=0).
REQ-017 ROUND SHALL add round = guard & (sticky | frac[0]) (round-to-nearest-even) to {e,frac} as an 18-bit sum, with carry propagating into the exponent.
REQ-018 Post-round bits [17:16] SHALL select exc: 00 -> 01 normal with R[15:0] = sum[15:0]; 01 -> 10 inf; 1x -> 00 zero; for inf/zero, R[15:0] SHALL be 0.
REQ-019 Latency SHALL be out_valid high from cycle T+13 for normal/normal and from cycle T+1 for special cases, where T is the acceptance cycle.
REQ-020 In DONE, out_valid SHALL be 1, R SHALL be held stable, and the FSM SHALL stay in DONE until out_ready=1, then go to IDLE on that edge.
REQ-021 out_ready SHALL be ignored outside DONE.
REQ-022 Only one operation SHALL be in flight at a time, so a new pair is accepted no earlier than the cycle after the handshake (minimum 14-cycle issue interval for normal/normal).

Reset
REQ-023 While rst_n=0, the FSM SHALL be IDLE, out_valid=0, R=0, the iteration counter, quotient and remainder registers SHALL be 0, and in_ready SHALL be 1.
REQ-024 Reset asserted in DIV, ROUND or DONE SHALL abort the operation with no output; the first acceptance SHALL be possible in the first clk edge after deassertion.

Structure
REQ-025 A shared package fp_8_8_pkg SHALL hold WE=8, WF=8, BIAS=127, the four exc encodings and the FSM state enum, and SHALL be shared with fmul.
REQ-026 The single sub-module fdiv_round_pack SHALL implement the combinational REQ-016..018 logic (normalise, round, exception pack); the divider datapath and FSM SHALL stay in fdiv_iter.

Verification
REQ-027 The bench SHALL check 3.0/2.0: X=0x28080, Y=0x28000 -> R=0x27F80, out_valid rising at T+13.
REQ-028 The bench SHALL check 1.0/3.0: X=0x27F00, Y=0x28080 -> R=0x27D55 (guard 0, no increment).
REQ-029 The bench SHALL check special cases: 1.0/0 (Y=0x00000) -> R=0x40000 at T+1; 0/0 -> R=0x60000; NaN input X=0x60000 -> R[18:17]=11.
REQ-030 The bench SHALL check range limits: X=0x2FE00, Y=0x20100 -> R=0x40000 (overflow); X=0x20100, Y=0x2FE00 -> R=0x00000 (underflow).
REQ-031 The bench SHALL check backpressure: hold out_ready=0 for 5 cycles in DONE -> R and out_valid stable, in_ready=0, and in_valid pulses ignored.
REQ-032 The bench SHALL check reset mid-DIV: pull rst_n low at T+5 -> out_valid=0 and R=0; after release, 1.0/1.0 (0x27F00/0x27F00) -> R=0x27F00.
